iram_ctrl: RTL and testbench
============================

IRAM_CTRL -- requirements
Module: iram_ctrl

Interface
REQ-001 Parameters: LINE_WORDS, 4, memory words per cache line (power of 2, >=2); WORD_BYTES, `memory_word/8, bytes per memory word.
REQ-002 clk  input  1  sole clock; all state updates on posedge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 miss_cache  input  1  refill request from fetch unit; level, held until line_done.
REQ-005 ram_address  input  `pc_size  byte address of the missing instruction.
REQ-006 mem_word  output  `memory_word  refilled word returned to fetch unit.
REQ-007 word_ready  output  1  one-cycle strobe: mem_word and word_idx are valid.
REQ-008 word_idx  output  $clog2(LINE_WORDS)  position of mem_word within the line.
REQ-009 line_done  output  1  one-cycle strobe, coincident with the last word_ready of a refill.
REQ-010 mem_req  output  1  backing-memory read request, held until mem_ack.
REQ-011 mem_addr  output  `pc_size  backing-memory byte address, stable while mem_req is high.
REQ-012 mem_ack  input  1  backing-memory completion; mem_rdata is valid in the same cycle.
REQ-013 mem_rdata  input  `memory_word  backing-memory read data.

Function
REQ-014 FSM states: IDLE, FETCH, DONE.
- IDLE->FETCH on miss_cache=1.
- FETCH->DONE on the mem_ack of the LINE_WORDS-th word.
- DONE->IDLE unconditionally after 1 cycle.
REQ-015 On the IDLE->FETCH edge: latch line base = ram_address with its low $clog2(LINE_WORDS*WORD_BYTES) bits cleared; latch start index = the ram_address word-offset field.
REQ-016 mem_addr = base + idx*WORD_BYTES; idx is a wrapping counter modulo LINE_WORDS, so the address never leaves the line.
REQ-017 mem_req is registered: high from the cycle after the miss is accepted until the cycle after the final mem_ack; it stays high across back-to-back words. Each mem_ack advances idx.
REQ-018 Per mem_ack: on the next edge, mem_word<=mem_rdata, word_idx<=current idx, word_ready=1 for one cycle. Latency mem_ack->word_ready is 1 cycle.
REQ-019 mem_ack while mem_req=0 is ignored.
REQ-020 miss_cache is sampled only in IDLE. Changes of miss_cache or ram_address during FETCH or DONE are ignored. miss_cache still high in IDLE after DONE starts a new refill.
REQ-021 Exactly LINE_WORDS word_ready pulses per refill, each idx delivered once. line_done is asserted with the last one.
REQ-022 mem_word holds its last value between strobes.

Reset
REQ-023 With rst=1 at a posedge: state=IDLE; mem_req, word_ready, line_done=0; mem_word, mem_addr, word_idx=0; counters cleared.
REQ-024 Reset mid-refill aborts the refill. No further strobes occur, and a mem_ack arriving after reset is ignored.

Configuration
REQ-025 Macro IRAM_CRITICAL_WORD_FIRST_EN.
- Defined: the first fetched idx is the start index (critical word first), then wrap-around order.
- Undefined: the first idx is always 0, in ascending order, and the start index is not stored.

Structure
REQ-026 The iram_state_t enum and the IRAM_LINE_WORDS default go in the shared constants package.
REQ-027 One sub-module, iram_burst_cnt: idx and word counter, wrap, last-word flag, mem_addr generation.

Verification (LINE_WORDS=4, 32-bit word and pc)
REQ-028 Miss at 0x0000_0108, mem_ack 2 cycles after each mem_req, CWF defined:
- mem_addr sequence 0x108, 0x10C, 0x100, 0x104.
- word_idx sequence 2, 3, 0, 1.
- line_done with idx 1.
REQ-029 Same miss, CWF undefined: mem_addr sequence 0x100, 0x104, 0x108, 0x10C; word_idx sequence 0..3.
REQ-030 mem_ack tied to 1: four consecutive word_ready cycles; mem_word equals mem_rdata delayed 1 cycle.
REQ-031 rst pulsed after the 2nd word_ready, then mem_ack=1: no further word_ready; all outputs are 0 on the next cycle.
REQ-032 ram_address changed to 0x200 mid-refill of 0x100, and miss_cache held high through line_done:
- mem_addr stays within 0x100-0x10C for the current refill.
- A second refill of 0x200 starts after DONE.
REQ-033 Spurious mem_ack while in IDLE: no word_ready, and the state stays IDLE.

Source files
------------

// File: rtl/iram_ctrl_pkg.sv
// Shared constants and state encoding for the instruction-RAM refill controller.
`ifndef MEMORY_WORD
`define MEMORY_WORD 32
`endif
`ifndef PC_SIZE
`define PC_SIZE 32
`endif

package iram_ctrl_pkg;
  localparam int IRAM_LINE_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } iram_state_t;
endpackage

// File: rtl/iram_burst_cnt.sv
// Line-burst sequencer: wrapping word index, words-fetched counter, last-word flag, mem_addr.
// IRAM_CRITICAL_WORD_FIRST_EN selects critical-word-first start instead of word 0.
`ifndef MEMORY_WORD
`define MEMORY_WORD 32
`endif
`ifndef PC_SIZE
`define PC_SIZE 32
`endif

module iram_burst_cnt #(
  parameter int LINE_WORDS = 4,
  parameter int WORD_BYTES = 4,
  parameter int PC_W       = 32,
  parameter int IDX_W      = $clog2(LINE_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [PC_W-1:0]  addr_i,
  input  logic             adv_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             last_o,
  output logic [PC_W-1:0]  mem_addr_o
);
  localparam int BYTE_W = $clog2(WORD_BYTES);
  localparam int OFF_W  = IDX_W + BYTE_W;
  localparam logic [PC_W-1:0] LINE_MASK = ~((PC_W'(1) << OFF_W) - PC_W'(1));

  logic [PC_W-1:0]  base_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      base_q <= addr_i & LINE_MASK;
`ifdef IRAM_CRITICAL_WORD_FIRST_EN
      idx_q  <= addr_i[OFF_W-1:BYTE_W];
`else
      idx_q  <= '0;
`endif
      cnt_q  <= '0;
    end else if (adv_i) begin
      // idx wraps naturally at LINE_WORDS (power of two), keeping the burst inside the line
      idx_q <= idx_q + IDX_W'(1);
      cnt_q <= cnt_q + IDX_W'(1);
    end
  end

  assign idx_o      = idx_q;
  assign last_o     = (cnt_q == IDX_W'(LINE_WORDS - 1));
  assign mem_addr_o = base_q + (PC_W'(idx_q) << BYTE_W);
endmodule

// File: rtl/iram_ctrl.sv
// Instruction-RAM line refill controller: fetches LINE_WORDS words per miss and strobes each back.
// IRAM_CRITICAL_WORD_FIRST_EN (in iram_burst_cnt) enables critical-word-first ordering.
`ifndef MEMORY_WORD
`define MEMORY_WORD 32
`endif
`ifndef PC_SIZE
`define PC_SIZE 32
`endif

module iram_ctrl
  import iram_ctrl_pkg::*;
#(
  parameter int LINE_WORDS = IRAM_LINE_WORDS,
  parameter int WORD_BYTES = `MEMORY_WORD / 8,
  parameter int IDX_W      = $clog2(LINE_WORDS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    miss_cache,
  input  logic [`PC_SIZE-1:0]     ram_address,
  output logic [`MEMORY_WORD-1:0] mem_word,
  output logic                    word_ready,
  output logic [IDX_W-1:0]        word_idx,
  output logic                    line_done,
  output logic                    mem_req,
  output logic [`PC_SIZE-1:0]     mem_addr,
  input  logic                    mem_ack,
  input  logic [`MEMORY_WORD-1:0] mem_rdata
);
  iram_state_t             state_q;
  logic                    mem_req_q;
  logic                    word_ready_q;
  logic                    line_done_q;
  logic [`MEMORY_WORD-1:0] mem_word_q;
  logic [IDX_W-1:0]        word_idx_q;

  logic             load;
  logic             adv;
  logic             last;
  logic [IDX_W-1:0] idx;

  // mem_req_q is only high in FETCH, so stray acks elsewhere never advance the burst
  assign load = (state_q == IDLE) && miss_cache;
  assign adv  = mem_req_q && mem_ack;

  iram_burst_cnt #(
    .LINE_WORDS (LINE_WORDS),
    .WORD_BYTES (WORD_BYTES),
    .PC_W       (`PC_SIZE),
    .IDX_W      (IDX_W)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .addr_i     (ram_address),
    .adv_i      (adv),
    .idx_o      (idx),
    .last_o     (last),
    .mem_addr_o (mem_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      word_ready_q <= 1'b0;
      line_done_q  <= 1'b0;
      mem_word_q   <= '0;
      word_idx_q   <= '0;
    end else begin
      word_ready_q <= 1'b0;
      line_done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (miss_cache) begin
            state_q   <= FETCH;
            mem_req_q <= 1'b1;
          end
        end
        FETCH: begin
          if (adv) begin
            mem_word_q   <= mem_rdata;
            word_idx_q   <= idx;
            word_ready_q <= 1'b1;
            if (last) begin
              line_done_q <= 1'b1;
              mem_req_q   <= 1'b0;
              state_q     <= DONE;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req    = mem_req_q;
  assign word_ready = word_ready_q;
  assign line_done  = line_done_q;
  assign mem_word   = mem_word_q;
  assign word_idx   = word_idx_q;
endmodule

// File: tb/tb_iram_ctrl.sv
// Scoreboard bench for iram_ctrl: directed refills, tied ack, mid-refill reset, spurious acks.
`ifndef MEMORY_WORD
`define MEMORY_WORD 32
`endif
`ifndef PC_SIZE
`define PC_SIZE 32
`endif

module tb_iram_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_cache = 1'b0;
  logic [31:0] ram_address = '0;
  logic [31:0] mem_word;
  logic        word_ready;
  logic [1:0]  word_idx;
  logic        line_done;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  typedef struct packed {
    logic [31:0] word;
    logic [1:0]  idx;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          ack_dly = 2;
  int          wcnt = 0;
  bit          tie = 1'b0;

  always #5 clk = ~clk;

  iram_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .miss_cache  (miss_cache),
    .ram_address (ram_address),
    .mem_word    (mem_word),
    .word_ready  (word_ready),
    .word_idx    (word_idx),
    .line_done   (line_done),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
  );

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return 32'hD000_0000 ^ a;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Expected burst: first n words of the line at base, in the configured fetch order
  task automatic expect_line(input logic [31:0] base, input int start, input int n);
    int          first;
    int          ix;
    logic [31:0] a;
    exp_t        e;
`ifdef IRAM_CRITICAL_WORD_FIRST_EN
    first = start;
`else
    first = 0;
`endif
    for (int k = 0; k < n; k++) begin
      ix     = (first + k) % 4;
      a      = base + 32'(ix * 4);
      e.word = data_of(a);
      e.idx  = 2'(ix);
      e.last = (k == 3);
      addr_q.push_back(a);
      exp_q.push_back(e);
    end
  endtask

  // sel: 0 word_ready, 1 line_done, 2 mem_req; returns on the negedge where it is seen
  task automatic wait_for(input int sel, input string name);
    int n;
    bit hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < 200) begin
      @(negedge clk);
      n++;
      hit = (sel == 0) ? word_ready : (sel == 1) ? line_done : mem_req;
    end
    check({name, " seen"}, 64'(hit), 64'd1);
  endtask

  // Backing-memory model: acks ack_dly idle cycles into each request, or constantly when tied
  always @(negedge clk) begin
    if (tie) begin
      mem_ack = 1'b1;
      wcnt    = 0;
    end else if (mem_req) begin
      if (wcnt == ack_dly) begin
        mem_ack = 1'b1;
        wcnt    = 0;
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end
    mem_rdata = data_of(mem_addr);
    if (mem_ack && mem_req) begin
      if (addr_q.size() == 0) check("acked mem_req expected", 64'(mem_req), 64'd0);
      else check("mem_addr", 64'(mem_addr), 64'(addr_q.pop_front()));
    end
  end

  // Monitor: every word_ready strobe is matched against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (word_ready) begin
      check("word_ready expected", 64'(word_ready), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("word/idx/line_done", 64'({mem_word, word_idx, line_done}),
              64'({e.word, e.idx, e.last}));
      end
    end else if (line_done) begin
      check("line_done without word_ready", 64'(line_done), 64'(word_ready));
    end
  end

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check("rst mem_req", 64'(mem_req), 64'd0);
    check("rst word_ready", 64'(word_ready), 64'd0);
    check("rst line_done", 64'(line_done), 64'd0);
    check("rst mem_word", 64'(mem_word), 64'd0);
    check("rst mem_addr", 64'(mem_addr), 64'd0);
    check("rst word_idx", 64'(word_idx), 64'd0);
    rst = 1'b0;

    // spurious acks while idle
    tie = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("idle ack word_ready", 64'(word_ready), 64'd0);
      check("idle ack mem_req", 64'(mem_req), 64'd0);
    end
    tie = 1'b0;
    @(negedge clk);

    // miss at 0x108, ack two cycles into each request
    ack_dly = 2;
    expect_line(32'h100, 2, 4);
    ram_address = 32'h108;
    miss_cache  = 1'b1;
    wait_for(1, "line_done 0x108");
    miss_cache = 1'b0;
    repeat (2) @(negedge clk);
    check("idle after refill mem_req", 64'(mem_req), 64'd0);

    // ack tied high: four back-to-back strobes
    expect_line(32'h300, 1, 4);
    tie         = 1'b1;
    ram_address = 32'h304;
    miss_cache  = 1'b1;
    wait_for(0, "tied first word_ready");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("tied consecutive word_ready", 64'(word_ready), 64'd1);
    end
    check("tied line_done on 4th", 64'(line_done), 64'd1);
    miss_cache = 1'b0;
    tie        = 1'b0;
    repeat (2) @(negedge clk);

    // reset after the second word of a refill
    ack_dly = 2;
    expect_line(32'h100, 2, 2);
    ram_address = 32'h108;
    miss_cache  = 1'b1;
    wait_for(0, "abort word 1");
    wait_for(0, "abort word 2");
    rst        = 1'b1;
    miss_cache = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("abort mem_req", 64'(mem_req), 64'd0);
    check("abort word_ready", 64'(word_ready), 64'd0);
    check("abort line_done", 64'(line_done), 64'd0);
    check("abort mem_word", 64'(mem_word), 64'd0);
    check("abort mem_addr", 64'(mem_addr), 64'd0);
    check("abort word_idx", 64'(word_idx), 64'd0);
    tie = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post-abort word_ready", 64'(word_ready), 64'd0);
    end
    tie = 1'b0;
    @(negedge clk);

    // address change mid-refill, miss held high into a second refill
    ack_dly = 1;
    expect_line(32'h100, 0, 4);
    expect_line(32'h200, 0, 4);
    ram_address = 32'h100;
    miss_cache  = 1'b1;
    wait_for(0, "first word 0x100");
    ram_address = 32'h200;
    wait_for(1, "line_done 0x100");
    wait_for(2, "second refill mem_req");
    miss_cache = 1'b0;
    wait_for(1, "line_done 0x200");
    repeat (3) @(negedge clk);
    check("final mem_req", 64'(mem_req), 64'd0);
    check("scoreboard words left", 64'(exp_q.size()), 64'd0);
    check("scoreboard addrs left", 64'(addr_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
